// File: rtl/pll_phase_sequencer_pkg.sv
// pll_ctrl_pkg: state encoding and constants shared by the PLL phase sequencer files
package pll_ctrl_pkg;
    localparam int PHASE_W = 8;
    localparam logic [2:0] COUNTER_SEL_ALL = 3'b000;
    typedef enum logic [3:0] {
        ST_IDLE, ST_CHECK, ST_SWITCH, ST_SETTLE, ST_PLAN,
        ST_STEP_ARM, ST_STEP_LOW, ST_STEP_HIGH, ST_DONE
    } pll_state_e;
endpackage

// File: rtl/pll_phase_sequencer_if.sv
// pll_phase_sequencer_if: Cyclone III PLL dynamic phase / clock-switch pins
interface pll_phase_sequencer_if;
    import pll_ctrl_pkg::*;
    logic [2:0] phasecounterselect;
    logic phaseupdown;
    logic phasestep;
    logic scanclk;
    logic clkswitch;
    logic phasedone;
    modport master (output phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, input phasedone);
    modport slave (input phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, output phasedone);
endinterface

// File: rtl/pll_phase_sequencer_scanclk_gen.sv
// scanclk_gen: free-running scanclk divider with one-cycle fall/rise strobes
module scanclk_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    output logic scanclk,
    output logic sc_fall,
    output logic sc_rise
);
    localparam int CW = $clog2(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = cnt == LAST;
    assign sc_fall = wrap & scanclk;
    assign sc_rise = wrap & ~scanclk;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            scanclk <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) scanclk <= ~scanclk;
        end
    end
endmodule

// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer: turns updatepll requests into PLL clkswitch pulses and phase steps.
// Optional PLL_STEP_TIMEOUT_EN adds a per-step phasedone timeout and sticky step_error.
module pll_phase_sequencer import pll_ctrl_pkg::*; #(
    parameter int SCANCLK_HALF = 4,
    parameter int CLKSWITCH_CYCLES = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter logic [2:0] COUNTER_SEL = COUNTER_SEL_ALL,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic updatepll,
    input  logic pll_clk_src,
    input  logic [PHASE_W-1:0] pll_clk_phase,
    pll_phase_sequencer_if.master pll,
    output logic busy,
    output logic cur_src,
    output logic [PHASE_W-1:0] cur_phase,
    output logic step_error
);
    localparam logic [3:0] IDLE = ST_IDLE;
    localparam logic [3:0] CHECK = ST_CHECK;
    localparam logic [3:0] SWITCH = ST_SWITCH;
    localparam logic [3:0] SETTLE = ST_SETTLE;
    localparam logic [3:0] PLAN = ST_PLAN;
    localparam logic [3:0] STEP_ARM = ST_STEP_ARM;
    localparam logic [3:0] STEP_LOW = ST_STEP_LOW;
    localparam logic [3:0] STEP_HIGH = ST_STEP_HIGH;
    localparam logic [3:0] DONE = ST_DONE;
    // one counter serves switch hold, settle and step timeout
    localparam int CMAX = CLKSWITCH_CYCLES > SETTLE_CYCLES
        ? (CLKSWITCH_CYCLES > TIMEOUT_CYCLES ? CLKSWITCH_CYCLES : TIMEOUT_CYCLES)
        : (SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    logic [3:0] state;
    logic [CW-1:0] cnt;
    logic pend, pend_src, tgt_src, dir, low_seen, pd_meta, pd_s;
    logic sc_fall, sc_rise, expire;
    logic [PHASE_W-1:0] pend_phase, tgt_phase, steps;
    logic [PHASE_W:0] diff;
    assign diff = {1'b0, tgt_phase} - {1'b0, cur_phase};
    assign pll.phasecounterselect = COUNTER_SEL;
`ifdef PLL_STEP_TIMEOUT_EN
    assign expire = (state == STEP_LOW || state == STEP_HIGH) && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign expire = 1'b0;
`endif
    scanclk_gen #(.HALF(SCANCLK_HALF)) u_scanclk (
        .clk(clk),
        .reset(reset),
        .scanclk(pll.scanclk),
        .sc_fall(sc_fall),
        .sc_rise(sc_rise)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            pend <= 1'b0;
            pend_src <= 1'b0;
            pend_phase <= '0;
            tgt_src <= 1'b0;
            tgt_phase <= '0;
            dir <= 1'b1;
            steps <= '0;
            low_seen <= 1'b0;
            pd_meta <= 1'b0;
            pd_s <= 1'b0;
            busy <= 1'b0;
            cur_src <= 1'b0;
            cur_phase <= '0;
            step_error <= 1'b0;
            pll.phasestep <= 1'b0;
            pll.phaseupdown <= 1'b1;
            pll.clkswitch <= 1'b0;
        end else begin
            pd_meta <= pll.phasedone;
            pd_s <= pd_meta;
            if (expire) begin
                pll.phasestep <= 1'b0;
                step_error <= 1'b1;
                state <= DONE;
            end else begin
                case (state)
                    IDLE: if (pend) begin
                        tgt_src <= pend_src;
                        tgt_phase <= pend_phase;
                        pend <= 1'b0;
                        busy <= 1'b1;
                        state <= CHECK;
                    end
                    CHECK: begin
                        cnt <= '0;
                        pll.clkswitch <= tgt_src != cur_src;
                        state <= tgt_src != cur_src ? SWITCH : PLAN;
                    end
                    SWITCH: if (cnt == CW'(CLKSWITCH_CYCLES - 1)) begin
                        cnt <= '0;
                        pll.clkswitch <= 1'b0;
                        cur_src <= tgt_src;
                        state <= SETTLE;
                    end else cnt <= cnt + 1'b1;
                    SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state <= PLAN;
                    else cnt <= cnt + 1'b1;
                    PLAN: begin
                        dir <= ~diff[PHASE_W];
                        steps <= diff[PHASE_W] ? ~diff[PHASE_W-1:0] + 1'b1 : diff[PHASE_W-1:0];
                        state <= diff == '0 ? DONE : STEP_ARM;
                    end
                    // phasestep/phaseupdown move only with scanclk falling so the PLL samples them stable
                    STEP_ARM: if (sc_fall) begin
                        pll.phasestep <= 1'b1;
                        pll.phaseupdown <= dir;
                        cnt <= '0;
                        low_seen <= 1'b0;
                        state <= STEP_LOW;
                    end
                    STEP_LOW: begin
                        cnt <= cnt + 1'b1;
                        low_seen <= low_seen | ~pd_s;
                        if (sc_fall && (low_seen || !pd_s)) begin
                            pll.phasestep <= 1'b0;
                            cnt <= '0;
                            state <= STEP_HIGH;
                        end
                    end
                    STEP_HIGH: begin
                        cnt <= cnt + 1'b1;
                        if (pd_s) begin
                            cur_phase <= dir ? cur_phase + 1'b1 : cur_phase - 1'b1;
                            steps <= steps - 1'b1;
                            state <= steps == 8'd1 ? DONE : STEP_ARM;
                        end
                    end
                    DONE: begin
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (updatepll) begin
                pend <= 1'b1;
                pend_src <= pll_clk_src;
                pend_phase <= pll_clk_phase;
            end
        end
    end
    assert property (@(posedge clk) disable iff (reset)
        sc_rise && !expire |=> $stable(pll.phasestep) && $stable(pll.phaseupdown));
endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb_pll_phase_sequencer: directed and random requests checked against a PLL-state model
module tb_pll_phase_sequencer;
    localparam int HALF = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic updatepll = 1'b0;
    logic pll_clk_src = 1'b0;
    logic [7:0] pll_clk_phase = 8'd0;
    logic busy, cur_src, step_error;
    logic [7:0] cur_phase;
    int errors = 0;
    int checks = 0;
    logic m_src = 1'b0;
    logic [7:0] m_phase = 8'd0;
    int steps_seen = 0, ups_seen = 0, cs_cycles = 0, viol = 0, rises = 0;
    logic ps_prev = 1'b0, pu_prev = 1'b1, sc_prev = 1'b0, busy_prev = 1'b0;
    logic pll_stuck = 1'b0;

    pll_phase_sequencer_if pif();

    pll_phase_sequencer dut (
        .clk(clk),
        .reset(reset),
        .updatepll(updatepll),
        .pll_clk_src(pll_clk_src),
        .pll_clk_phase(pll_clk_phase),
        .pll(pif.master),
        .busy(busy),
        .cur_src(cur_src),
        .cur_phase(cur_phase),
        .step_error(step_error)
    );

    always #5 clk = ~clk;

    // PLL: phasedone drops 3 scanclk periods after a step, returns 2 periods later
    initial begin
        pif.phasedone = 1'b1;
        forever begin
            @(posedge clk);
            if (pif.phasestep && !pll_stuck) begin
                repeat (6 * HALF) @(posedge clk);
                #1 pif.phasedone = 1'b0;
                repeat (4 * HALF) @(posedge clk);
                #1 pif.phasedone = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if ((pif.phasestep !== ps_prev || pif.phaseupdown !== pu_prev) && !(sc_prev && !pif.scanclk) && !reset)
            viol <= viol + 1;
        if (pif.phasestep && !ps_prev) begin
            steps_seen <= steps_seen + 1;
            if (pif.phaseupdown) ups_seen <= ups_seen + 1;
        end
        if (pif.clkswitch) cs_cycles <= cs_cycles + 1;
        if (busy && !busy_prev) rises <= rises + 1;
        ps_prev <= pif.phasestep;
        pu_prev <= pif.phaseupdown;
        sc_prev <= pif.scanclk;
        busy_prev <= busy;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic s, input logic [7:0] p);
        @(posedge clk);
        #1 updatepll = 1'b1;
        pll_clk_src = s;
        pll_clk_phase = p;
        @(posedge clk);
        #1 updatepll = 1'b0;
    endtask

    task automatic wait_low(output int hi);
        hi = 0;
        while (busy && hi < 20000) begin
            hi++;
            @(negedge clk);
        end
        check("busy_bounded", int'(busy), 0);
        #1;
    endtask

    task automatic req(input logic s, input logic [7:0] p);
        int hi, st, b_steps, b_ups, b_cs, b_v;
        logic sw, up;
        sw = s != m_src;
        up = p > m_phase;
        st = up ? int'(p - m_phase) : int'(m_phase - p);
        b_steps = steps_seen;
        b_ups = ups_seen;
        b_cs = cs_cycles;
        b_v = viol;
        strobe(s, p);
        @(negedge clk);
        check("busy_early", int'(busy), 0);
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
        wait_low(hi);
        check("cur_phase", int'(cur_phase), int'(p));
        check("cur_src", int'(cur_src), int'(s));
        check("steps", steps_seen - b_steps, st);
        check("up_steps", ups_seen - b_ups, up ? st : 0);
        check("clkswitch_cycles", cs_cycles - b_cs, sw ? 8 : 0);
        check("step_on_scanclk_fall", viol - b_v, 0);
        if (st == 0) check("busy_len", hi, sw ? 27 : 3);
        m_src = s;
        m_phase = p;
    endtask

    initial begin
        int hi, b_steps, b_ups, b_r, n;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_cur_phase", int'(cur_phase), 0);
        check("rst_cur_src", int'(cur_src), 0);
        check("rst_phasestep", int'(pif.phasestep), 0);
        check("rst_phaseupdown", int'(pif.phaseupdown), 1);
        check("rst_clkswitch", int'(pif.clkswitch), 0);
        check("rst_scanclk", int'(pif.scanclk), 0);
        check("rst_cntsel", int'(pif.phasecounterselect), 0);
        check("rst_step_error", int'(step_error), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        req(1'b0, 8'd0);
        req(1'b0, 8'd5);
        req(1'b0, 8'd2);
        req(1'b1, 8'd2);

        // queued strobes during a sequence: only the last one is serviced afterwards
        b_steps = steps_seen;
        strobe(m_src, 8'd3);
        repeat (4) @(posedge clk);
        strobe(m_src, 8'd10);
        strobe(m_src, 8'd20);
        @(negedge clk);
        wait_low(hi);
        check("retarget_first", int'(cur_phase), 3);
        check("retarget_first_steps", steps_seen - b_steps, 1);
        b_r = rises;
        b_steps = steps_seen;
        b_ups = ups_seen;
        n = 0;
        while (!busy && n < 10) begin
            n++;
            @(negedge clk);
        end
        wait_low(hi);
        check("retarget_final", int'(cur_phase), 20);
        check("retarget_steps", steps_seen - b_steps, 17);
        check("retarget_up", ups_seen - b_ups, 17);
        repeat (20) @(negedge clk);
        #1 check("retarget_one_seq", rises - b_r, 1);
        m_phase = 8'd20;

        for (int i = 0; i < 6; i++)
            req(1'(($urandom_range(0, 1))), 8'($urandom_range(0, 12)));

        // reset in the middle of step 3 of 5, with a request pending
        b_steps = steps_seen;
        strobe(m_src, m_phase + 8'd5);
        n = 0;
        while (steps_seen - b_steps < 3 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("reach_step3", steps_seen - b_steps, 3);
        strobe(1'b0, 8'd9);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_phasestep", int'(pif.phasestep), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cur_phase", int'(cur_phase), 0);
        check("mid_rst_scanclk", int'(pif.scanclk), 0);
        check("mid_rst_phaseupdown", int'(pif.phaseupdown), 1);
        reset = 1'b0;
        m_src = 1'b0;
        m_phase = 8'd0;
        b_r = rises;
        repeat (100) @(negedge clk);
        #1 check("pending_dropped", rises - b_r, 0);

`ifdef PLL_STEP_TIMEOUT_EN
        pll_stuck = 1'b1;
        strobe(1'b0, 8'd4);
        @(negedge clk);
        @(negedge clk);
        wait_low(hi);
        check("timeout_error", int'(step_error), 1);
        check("timeout_phase", int'(cur_phase), 0);
        check("timeout_long", int'(hi >= 1024), 1);
        pll_stuck = 1'b0;
        repeat (20) @(negedge clk);
`endif

        req(1'b0, 8'd3);
`ifndef PLL_STEP_TIMEOUT_EN
        check("step_error_tied", int'(step_error), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
